// File: rtl/sparsity_block_sequencer.sv
// ---------------------------------------------------------------------------
// sparsity_block_sequencer
//
// Streams a run of N weight/activation blocks through an external
// sparsity_selector and hands each block, with the mask the selector chose
// for it, to the sparse packer / PE feed on a valid/ready stream.
//
// The selector registers its mask one cycle after it sees data. This block
// feeds it the incoming block on the accept edge. On every other cycle it
// feeds the held output block. That way the mask always lines up with
// out_data and stays stable while the output is stalled.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   cmd_*             run command: block count, sparsity mode, bypass
//   cmd_ready         high only while idle
//   in_valid/in_ready/in_data      block fetch stream (lane 0 at LSBs)
//   sel_data/sel_mode/sel_enable   drive to the selector
//   sel_mask                       registered mask from the selector
//   out_valid/out_ready            output block stream handshake
//   out_data/out_mask/out_last     output block, its mask, final-block flag
//   kept_count        elements kept so far in this run (held after done)
//   busy              a run is in progress
//   done              one-cycle pulse when a run completes
// ---------------------------------------------------------------------------
module sparsity_block_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int BLOCK_SIZE = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    // command
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [CNT_WIDTH-1:0]             cmd_num_blocks,
    input  logic [1:0]                       cmd_mode,
    input  logic                             cmd_bypass,
    // input block stream
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH*BLOCK_SIZE-1:0] in_data,
    // selector interface
    output logic [DATA_WIDTH*BLOCK_SIZE-1:0] sel_data,
    output logic [1:0]                       sel_mode,
    output logic                             sel_enable,
    input  logic [BLOCK_SIZE-1:0]            sel_mask,
    // output block stream
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH*BLOCK_SIZE-1:0] out_data,
    output logic [BLOCK_SIZE-1:0]            out_mask,
    output logic                             out_last,
    // status
    output logic [CNT_WIDTH+2:0]             kept_count,
    output logic                             busy,
    output logic                             done
);

    localparam int KEPT_W = CNT_WIDTH + 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_WIDTH-1:0] num_blocks;
    logic [CNT_WIDTH-1:0] acc_cnt;
    logic [CNT_WIDTH:0]   acc_plus1;

    logic cmd_fire;
    logic in_fire;
    logic out_fire;
    logic more_in;
    logic is_last_in;

    // Number of kept lanes in a mask, already widened to the accumulator.
    function automatic logic [KEPT_W-1:0] popcount(input logic [BLOCK_SIZE-1:0] m);
        logic [KEPT_W-1:0] c;
        c = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            c = c + KEPT_W'(m[i]);
        end
        return c;
    endfunction

    // ---------------- handshakes ----------------
    assign cmd_fire = cmd_valid & cmd_ready;
    assign more_in  = (acc_cnt < num_blocks);
    // The output register may take a new block when it is empty or being
    // drained in this same cycle. That gives back-to-back throughput.
    assign in_ready = (state == RUN) & more_in & (~out_valid | out_ready);
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // One extra bit so the compare with N cannot overflow.
    assign acc_plus1  = {1'b0, acc_cnt} + (CNT_WIDTH + 1)'(1);
    assign is_last_in = (acc_plus1 == {1'b0, num_blocks});

    // ---------------- selector drive ----------------
    // On the accept edge the selector samples the new block. Otherwise it
    // re-samples the held block, so its registered mask keeps matching
    // out_data through any stall.
    assign sel_data = in_fire ? in_data : out_data;
    assign out_mask = sel_mask;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_fire) begin
                    // An empty run has nothing to stream; finish right away.
                    state_next = (cmd_num_blocks == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (out_fire && out_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------- run registers and output block ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            num_blocks <= '0;
            acc_cnt    <= '0;
            sel_mode   <= 2'd0;
            sel_enable <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            kept_count <= '0;
        end else if (cmd_fire) begin
            // Mode and enable stay frozen for the whole run, because
            // commands are accepted only while idle.
            num_blocks <= cmd_num_blocks;
            acc_cnt    <= '0;
            sel_mode   <= cmd_mode;
            sel_enable <= ~cmd_bypass;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            kept_count <= '0;
        end else begin
            if (in_fire) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
                out_last  <= is_last_in;
                acc_cnt   <= acc_plus1[CNT_WIDTH-1:0];
            end else if (out_fire) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (out_fire) begin
                kept_count <= kept_count + popcount(sel_mask);
            end
        end
    end

endmodule

// File: tb/tb_sparsity_block_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sparsity_block_sequencer
//
// Directed bench for sparsity_block_sequencer. The bench includes a small
// stand-in for the sparsity selector: top-k magnitude pick with a
// one-cycle registered mask. One stimulus process drives commands, blocks
// and out_ready. One compare process checks every cycle against a model
// built from expected-block lists and run bookkeeping.
// ---------------------------------------------------------------------------
module tb_sparsity_block_sequencer;

    localparam int DW = 8;
    localparam int BS = 4;
    localparam int CW = 16;
    localparam int BW = DW * BS;
    localparam int KW = CW + 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [CW-1:0] cmd_num_blocks;
    logic [1:0]    cmd_mode;
    logic          cmd_bypass;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_data;
    logic [BW-1:0] sel_data;
    logic [1:0]    sel_mode;
    logic          sel_enable;
    logic [BS-1:0] sel_mask;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_data;
    logic [BS-1:0] out_mask;
    logic          out_last;
    logic [KW-1:0] kept_count;
    logic          busy;
    logic          done;

    sparsity_block_sequencer #(
        .DATA_WIDTH(DW),
        .BLOCK_SIZE(BS),
        .CNT_WIDTH (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_num_blocks(cmd_num_blocks),
        .cmd_mode      (cmd_mode),
        .cmd_bypass    (cmd_bypass),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .sel_data      (sel_data),
        .sel_mode      (sel_mode),
        .sel_enable    (sel_enable),
        .sel_mask      (sel_mask),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_mask      (out_mask),
        .out_last      (out_last),
        .kept_count    (kept_count),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Selector behaviour: keep the k largest magnitudes. Ties go to the
    // lower lane. Mode 00 keeps half, mode 01 keeps a quarter, and other
    // modes or a disabled selector keep everything.
    function automatic logic [BS-1:0] sel_fn(input logic [BW-1:0] d, input logic [1:0] m,
                                             input logic en);
        int mag [BS];
        int k;
        int rank;
        logic signed [DW-1:0] v;
        logic [BS-1:0] r;
        for (int i = 0; i < BS; i++) begin
            v = d[i*DW +: DW];
            mag[i] = (v < 0) ? -int'(v) : int'(v);
        end
        if (!en)             k = BS;
        else if (m == 2'd0)  k = BS / 2;
        else if (m == 2'd1)  k = BS / 4;
        else                 k = BS;
        r = '0;
        for (int i = 0; i < BS; i++) begin
            rank = 0;
            for (int j = 0; j < BS; j++) begin
                if (mag[j] > mag[i] || (mag[j] == mag[i] && j < i)) rank++;
            end
            r[i] = (rank < k);
        end
        return r;
    endfunction

    always @(posedge clk) sel_mask <= sel_fn(sel_data, sel_mode, sel_enable);

    function automatic logic [BW-1:0] blk(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    // ---------------- stimulus-owned state ----------------
    logic [BW-1:0] src_blk [16];
    int            src_cnt, src_idx;
    int            cq_n [8];
    logic [1:0]    cq_m [8];
    logic          cq_b [8];
    int            cq_cnt, cq_idx;
    int            rc, st_lo, st_hi;
    logic [BW-1:0] exp_data [64];
    logic [BS-1:0] exp_mask [64];
    logic          exp_last [64];
    int            exp_wr;
    int            lit_req, lk, lm, ll, la;
    int            tmo_cnt;

    // ---------------- compare-owned state ----------------
    int            errors, checks;
    int            ccyc, exp_rd, exp_kept, fire_cyc, lat, done_cnt, lit_seen;
    bit            run_open, exp_done, rst_pend, prev_stall, nd;
    logic [BW-1:0] hold_data;
    logic [BS-1:0] hold_mask, last_mask;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, ccyc);
        end
    endtask

    initial begin
        errors = 0; checks = 0; ccyc = 0; exp_rd = 0; exp_kept = 0; fire_cyc = 0;
        lat = 0; done_cnt = 0; lit_seen = 0; run_open = 0; exp_done = 0;
        rst_pend = 1; prev_stall = 0; hold_data = '0; hold_mask = '0; last_mask = '0;
    end

    always @(negedge clk) begin
        ccyc++;
        if (rst_pend) begin
            chk("rst_cmd_ready", cmd_ready, 1);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_last", out_last, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_kept", kept_count, 0);
            chk("rst_sel_mode", sel_mode, 0);
            chk("rst_sel_enable", sel_enable, 0);
        end else begin
            chk("busy", busy, run_open);
            chk("cmd_ready", cmd_ready, !run_open);
            chk("done", done, exp_done);
            chk("kept_count", kept_count, exp_kept);
            if (!run_open) begin
                chk("idle_in_ready", in_ready, 0);
                chk("idle_out_valid", out_valid, 0);
            end
            if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
            if (prev_stall) begin
                chk("stall_hold_valid", out_valid, 1);
                chk("stall_hold_data", out_data, hold_data);
                chk("stall_hold_mask", out_mask, hold_mask);
            end
            if (done) begin
                done_cnt++;
                lat = ccyc - fire_cyc;
            end
            if (lit_req != lit_seen) begin
                lit_seen = lit_req;
                chk("lit_kept", kept_count, lk);
                if (lm >= 0) chk("lit_mask", last_mask, lm);
                if (ll >= 0) chk("lit_latency", lat, ll);
                chk("lit_accepted", src_idx, la);
                chk("lit_pending_blocks", exp_wr - exp_rd, 0);
                chk("lit_timeouts", tmo_cnt, 0);
            end
        end
        // model update for the coming clock edge
        if (reset) begin
            rst_pend   = 1;
            run_open   = 0;
            exp_done   = 0;
            exp_kept   = 0;
            prev_stall = 0;
            exp_rd     = exp_wr;
        end else begin
            rst_pend = 0;
            nd = 0;
            if (exp_done) run_open = 0;
            if (cmd_valid && cmd_ready) begin
                chk("cmd_fire_while_running", run_open, 0);
                run_open = 1;
                exp_kept = 0;
                fire_cyc = ccyc;
                nd = (cmd_num_blocks == '0);
            end
            if (out_valid && out_ready) begin
                if (exp_rd >= exp_wr) begin
                    chk("unexpected_out_valid", out_valid, 0);
                end else begin
                    chk("out_data", out_data, exp_data[exp_rd]);
                    chk("out_mask", out_mask, exp_mask[exp_rd]);
                    chk("out_last", out_last, exp_last[exp_rd]);
                    exp_kept += $countones(exp_mask[exp_rd]);
                    if (exp_last[exp_rd]) nd = 1;
                    last_mask = out_mask;
                    exp_rd++;
                end
            end
            prev_stall = out_valid && !out_ready;
            hold_data  = out_data;
            hold_mask  = out_mask;
            exp_done   = nd;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive();
        in_valid       = (src_idx < src_cnt);
        in_data        = (src_idx < src_cnt) ? src_blk[src_idx] : '0;
        cmd_valid      = (cq_idx < cq_cnt);
        cmd_num_blocks = (cq_idx < cq_cnt) ? CW'(cq_n[cq_idx]) : '0;
        cmd_mode       = (cq_idx < cq_cnt) ? cq_m[cq_idx] : 2'd0;
        cmd_bypass     = (cq_idx < cq_cnt) ? cq_b[cq_idx] : 1'b0;
        out_ready      = !(rc >= st_lo && rc < st_hi);
    endtask

    task automatic tick();
        logic f_in, f_cmd;
        @(negedge clk);
        f_in  = in_valid && in_ready && !reset;
        f_cmd = cmd_valid && cmd_ready && !reset;
        @(posedge clk);
        #1;
        if (f_in) src_idx++;
        if (f_cmd) cq_idx++;
        rc++;
        drive();
    endtask

    task automatic clear_stim();
        src_cnt = 0; src_idx = 0; cq_cnt = 0; cq_idx = 0;
        rc = 0; st_lo = 0; st_hi = 0;
    endtask

    task automatic blk_add(input logic [BW-1:0] d, input logic [1:0] m, input logic byp,
                           input bit expect_out, input bit last);
        src_blk[src_cnt] = d;
        src_cnt++;
        if (expect_out) begin
            exp_data[exp_wr] = d;
            exp_mask[exp_wr] = sel_fn(d, m, !byp);
            exp_last[exp_wr] = last;
            exp_wr++;
        end
    endtask

    task automatic cmd_add(input int n, input logic [1:0] m, input logic byp);
        cq_n[cq_cnt] = n;
        cq_m[cq_cnt] = m;
        cq_b[cq_cnt] = byp;
        cq_cnt++;
    endtask

    task automatic wait_dones(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 400) begin
            tick();
            n++;
        end
        if (done_cnt < target) tmo_cnt++;
    endtask

    task automatic post_lit(input int k, input int m, input int l, input int a);
        lk = k; lm = m; ll = l; la = a;
        lit_req++;
        tick();
        tick();
    endtask

    logic [BW-1:0] b0, b1, b2, b3;
    int            base;

    initial begin
        reset = 1'b1;
        in_valid = 0; in_data = '0; cmd_valid = 0; cmd_num_blocks = '0;
        cmd_mode = 2'd0; cmd_bypass = 0; out_ready = 1;
        exp_wr = 0; lit_req = 0; lk = 0; lm = -1; ll = -1; la = 0; tmo_cnt = 0;
        clear_stim();
        b0 = blk(5, -9, 2, 7);
        b1 = blk(1, 2, 3, 4);
        b2 = blk(-3, 0, 8, -1);
        b3 = blk(100, -128, 1, 2);
        tick(); tick(); tick();
        reset = 1'b0;
        drive();
        tick(); tick();

        // basic 2:4 run, full throughput
        clear_stim();
        for (int i = 0; i < 3; i++) blk_add(b0, 2'd0, 1'b0, 1'b1, i == 2);
        cmd_add(3, 2'd0, 1'b0);
        drive();
        base = done_cnt;
        wait_dones(base + 1);
        post_lit(6, 4'b1010, 5, 3);

        // mode 01: one lane per block
        clear_stim();
        for (int i = 0; i < 3; i++) blk_add(b0, 2'd1, 1'b0, 1'b1, i == 2);
        cmd_add(3, 2'd1, 1'b0);
        drive();
        base = done_cnt;
        wait_dones(base + 1);
        post_lit(3, 4'b0010, 5, 3);

        // bypass keeps every lane
        clear_stim();
        for (int i = 0; i < 2; i++) blk_add(b0, 2'd1, 1'b1, 1'b1, i == 1);
        cmd_add(2, 2'd1, 1'b1);
        drive();
        base = done_cnt;
        wait_dones(base + 1);
        post_lit(8, 4'b1111, 4, 2);

        // backpressure: out_ready low for three cycles mid-stream
        clear_stim();
        blk_add(b0, 2'd0, 1'b0, 1'b1, 1'b0);
        blk_add(b1, 2'd0, 1'b0, 1'b1, 1'b0);
        blk_add(b2, 2'd0, 1'b0, 1'b1, 1'b0);
        blk_add(b3, 2'd0, 1'b0, 1'b1, 1'b1);
        cmd_add(4, 2'd0, 1'b0);
        st_lo = 2; st_hi = 5;
        drive();
        base = done_cnt;
        wait_dones(base + 1);
        post_lit(8, 4'b0011, -1, 4);

        // zero-length run: no block accepted
        clear_stim();
        blk_add(b0, 2'd0, 1'b0, 1'b0, 1'b0);
        cmd_add(0, 2'd0, 1'b0);
        drive();
        base = done_cnt;
        wait_dones(base + 1);
        post_lit(0, -1, 1, 0);

        // N=2 with five blocks offered: only two accepted
        clear_stim();
        for (int i = 0; i < 5; i++) blk_add(b0, 2'd0, 1'b0, i < 2, i == 1);
        cmd_add(2, 2'd0, 1'b0);
        drive();
        base = done_cnt;
        wait_dones(base + 1);
        for (int i = 0; i < 5; i++) tick();
        post_lit(4, 4'b1010, 4, 2);

        // reset after two of five blocks, then a clean run
        clear_stim();
        for (int i = 0; i < 5; i++) blk_add(b0, 2'd0, 1'b0, 1'b1, i == 4);
        cmd_add(5, 2'd0, 1'b0);
        drive();
        for (int n = 0; n < 50 && src_idx < 2; n++) tick();
        if (src_idx < 2) tmo_cnt++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_stim();
        drive();
        tick(); tick();
        blk_add(b0, 2'd0, 1'b0, 1'b1, 1'b0);
        blk_add(b1, 2'd0, 1'b0, 1'b1, 1'b1);
        cmd_add(2, 2'd0, 1'b0);
        drive();
        base = done_cnt;
        wait_dones(base + 1);
        post_lit(4, 4'b1100, 4, 2);

        // back-to-back commands: second is held valid during the first run
        clear_stim();
        blk_add(b0, 2'd0, 1'b0, 1'b1, 1'b0);
        blk_add(b0, 2'd0, 1'b0, 1'b1, 1'b1);
        blk_add(b0, 2'd1, 1'b0, 1'b1, 1'b0);
        blk_add(b0, 2'd1, 1'b0, 1'b1, 1'b1);
        cmd_add(2, 2'd0, 1'b0);
        cmd_add(2, 2'd1, 1'b0);
        drive();
        base = done_cnt;
        wait_dones(base + 2);
        post_lit(2, 4'b0010, 4, 4);

        tick(); tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sparsity_block_sequencer.md
Name: sparsity_block_sequencer

Overview:
- Command-driven controller that streams a run of N weight/activation blocks through a `sparsity_selector` instance.
- Handles the selector's 1-cycle registered mask latency and holds the selector input stable under output backpressure.
- Emits each block with its mask on a valid/ready stream, plus a kept-element count and a completion pulse.
- Sits between the block fetch stream and the sparse packer/PE feed.

Parameters:
DATA_WIDTH, 8, bits per element
BLOCK_SIZE, 4, elements per block (selector lanes); must be <=8
CNT_WIDTH, 16, width of block counters

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE
cmd_num_blocks  in  CNT_WIDTH  blocks in this run
cmd_mode  in  2  sparsity mode, passed to selector
cmd_bypass  in  1  1 = sparsity disabled (selector keeps all)
in_valid  in  1  input block valid
in_ready  out  1  input block accepted when in_valid&in_ready
in_data  in  DATA_WIDTH*BLOCK_SIZE  block, lane 0 at LSBs
sel_data  out  DATA_WIDTH*BLOCK_SIZE  to selector data_in
sel_mode  out  2  to selector sparsity_mode
sel_enable  out  1  to selector sparsity_enable
sel_mask  in  BLOCK_SIZE  from selector mask_out (registered, 1-cycle latency)
out_valid  out  1  output block valid
out_ready  in  1  downstream accept
out_data  out  DATA_WIDTH*BLOCK_SIZE  accepted block
out_mask  out  BLOCK_SIZE  mask for out_data
out_last  out  1  out block is block N-1 of the run
kept_count  out  CNT_WIDTH+3  sum of popcount(out_mask) over fired outputs this run
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at run completion

Behaviour:
- Reset values:
  - state=IDLE, cmd_ready=1, busy=0, done=0.
  - in_ready=0, out_valid=0, out_last=0.
  - out_data=0, kept_count=0.
  - sel_mode=0, sel_enable=0; internal counters 0.
- States:
  - IDLE -> RUN on command fire.
  - RUN -> DONE on the out fire with out_last.
  - DONE -> IDLE after exactly one cycle; done=1 only in DONE.
- Command fire (cmd_valid & cmd_ready):
  - Latch mode to sel_mode and sel_enable=~cmd_bypass; both are held constant until the next command.
  - Latch N; clear acc_cnt, out_cnt and kept_count.
  - N=0: go straight to DONE; no input is accepted; kept_count=0.
- Input side:
  - in_ready = RUN & (acc_cnt<N) & (~out_valid | out_ready).
  - In-fire: out_data<=in_data, out_valid<=1, out_last<=(acc_cnt==N-1), acc_cnt++.
- Selector drive:
  - sel_data = in_fire ? in_data : out_data (combinational).
  - The selector registers the mask on the in-fire edge, so sel_mask matches out_data in the cycle out_valid rises.
  - During a stall, the selector re-samples out_data, so the mask stays stable.
  - out_mask = sel_mask (combinational passthrough).
- Output side:
  - Out-fire (out_valid & out_ready) without a simultaneous in-fire: out_valid<=0.
  - Out-fire with a simultaneous in-fire: out_valid stays 1 with the new block. Full throughput is 1 block/cycle.
  - Each out-fire: kept_count += popcount(out_mask), out_cnt++.
  - out_valid, out_data and out_mask are stable while out_valid & ~out_ready.
- kept_count holds its value after done until the next command fire.
- Blocks beyond N are never accepted (in_ready=0 once acc_cnt==N).
- Mode or bypass changes mid-run are impossible: cmd_ready=0 outside IDLE.
- Reset mid-run: all state is discarded immediately; in-flight blocks are lost; no done pulse is generated.
- Counters do not wrap: N <= 2^CNT_WIDTH-1. kept_count width covers N*BLOCK_SIZE for BLOCK_SIZE<=8.

Test Plan:
- Basic 2:4 run:
  - Stimulus: cmd N=3, mode=00, bypass=0; blocks lanes(0..3)=(5,-9,2,7) x3; out_ready=1.
  - Required: out_mask=4'b1010 each block, out_last on the 3rd block only, 1 block/cycle, kept_count=6, done pulse 1 cycle after the last out fire, cmd_ready=1 the next cycle.
- Mode 01 and bypass:
  - Same block with mode=01: out_mask=4'b0010, kept_count=1 per block.
  - bypass=1 (any mode): out_mask=4'b1111, kept_count=4N.
- Backpressure:
  - Stimulus: N=4, out_ready low for 3 cycles mid-stream.
  - Required: out_data and out_mask are held unchanged while stalled, in_ready=0 while stalled, no block dropped or duplicated, order preserved, kept_count correct.
- Zero-length and limits:
  - N=0: done pulse within 2 cycles of the command fire, no in_ready, kept_count=0.
  - N=2 with 5 blocks offered: only 2 are accepted.
- Reset mid-run:
  - Stimulus: assert reset after 2 of 5 blocks.
  - Required: next cycle all outputs are at reset values, no done pulse.
  - A new command then runs cleanly, with kept_count starting from 0.
- Back-to-back commands:
  - Stimulus: 2nd command held valid during the 1st run.
  - Required: it is accepted only in IDLE after done; the new mode takes effect on the first block of the 2nd run.
